// File: rtl/si_pkg.sv
// Shared types and helpers for the si_frame_tx serial frame transmitter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package si_pkg;

  // Transmitter sequencing: address the bank, wait for data, shift, idle gap, finish.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } si_state_t;

  // Legacy link profiles: upload carries 3b index + 18b data, download 5b index + 8b data.
  localparam int UPLOAD_IW   = 3;
  localparam int UPLOAD_DW   = 18;
  localparam int DOWNLOAD_IW = 5;
  localparam int DOWNLOAD_DW = 8;

  // Parity helper takes a zero-extended vector; zeros do not change even parity.
  localparam int PAR_MAXW = 64;

  function automatic int frame_width(input int iw, input int dw, input int par_en);
    return iw + dw + ((par_en != 0) ? 1 : 0);
  endfunction

  function automatic logic even_parity(input logic [PAR_MAXW-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/si_frame_tx_if.sv
// Bundle of the transfer handshake, bank port and serial link of si_frame_tx.
// Latency: none, wiring only.
// Backpressure: none; the serial link has no flow control.
interface si_frame_tx_if #(
  parameter int DW  = 18,
  parameter int MAW = 3
);
  logic           start;
  logic           busy;
  logic           done;
  logic           mem_rw;
  logic [MAW-1:0] mem_a;
  logic [DW-1:0]  mem_q;
  logic           sen;
  logic           sd;

  // Transmitter side.
  modport master (
    input  start, mem_q,
    output busy, done, mem_rw, mem_a, sen, sd
  );

  // Controller / bank / receiver side.
  modport slave (
    output start, mem_q,
    input  busy, done, mem_rw, mem_a, sen, sd
  );
endinterface

// File: rtl/si_shift_out.sv
// Parallel-load MSB-first shift register; its MSB flop is the serial data line.
// Latency: loaded MSB appears on sd the cycle after load; one bit per shift.
// Backpressure: none; caller owns load/shift/clr timing.
module si_shift_out #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         sd
);
  logic [W-1:0] sreg;

  // Clear wins over load, load over shift; clearing parks sd at 0 between frames.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign sd = sreg[W-1];
endmodule

// File: rtl/si_frame_tx.sv
// Reads NFRAMES bank words and sends each as {index, data, parity} MSB first on sen/sd.
// Latency: sen falls 2 cycles after start is accepted; done NFRAMES*(FW+2)+(NFRAMES-1)*GAP+1 later.
// Backpressure: none; start is ignored while busy or while done is high, never queued.
module si_frame_tx
  import si_pkg::*;
#(
  parameter int IW        = UPLOAD_IW,
  parameter int DW        = UPLOAD_DW,
  parameter int MAW       = 3,
  parameter int NFRAMES   = 8,
  parameter int BASE_ADDR = 0,
  parameter int PARITY_EN = 0,
  parameter int GAP       = 0
) (
  input logic           clk,
  input logic           rst,
  si_frame_tx_if.master bus
);
  localparam int FW   = frame_width(IW, DW, PARITY_EN);
  localparam int IDXW = $clog2(NFRAMES + 1);
  localparam int BCW  = $clog2(FW + 1);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NFRAMES - 1);
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(FW - 1);
  // Unreachable when GAP is 0 because the GAP state is then never entered.
  localparam logic [7:0]      GAP_LAST = 8'(GAP - 1);
  localparam logic [MAW-1:0]  BASE     = MAW'(BASE_ADDR);

  si_state_t       state, state_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic [BCW-1:0]  bcnt, bcnt_nxt;
  logic [7:0]      gcnt, gcnt_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            sen_q, sen_nxt;
  logic [MAW-1:0]  mem_a_q, mem_a_nxt;

  logic            sh_load, sh_shift, sh_clr;
  logic [IW-1:0]   fidx;
  logic [FW-1:0]   frame;

  assign fidx = IW'(idx);

  generate
    if (PARITY_EN != 0) begin : g_par
      assign frame = {fidx, bus.mem_q, even_parity(PAR_MAXW'({fidx, bus.mem_q}))};
    end else begin : g_nopar
      assign frame = {fidx, bus.mem_q};
    end
  endgenerate

  // Next-state and next-register values; every output of the block is a flop.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bcnt_nxt  = bcnt;
    gcnt_nxt  = gcnt;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    sen_nxt   = sen_q;
    mem_a_nxt = mem_a_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_clr    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // done is still high in the first idle cycle; a start there belongs to the old transfer.
        if (bus.start && !done_q) begin
          state_nxt = ST_FETCH;
          busy_nxt  = 1'b1;
          mem_a_nxt = BASE + MAW'(idx);
        end
      end
      ST_FETCH: begin
        state_nxt = ST_READ;
      end
      ST_READ: begin
        sh_load   = 1'b1;
        sen_nxt   = 1'b0;
        bcnt_nxt  = '0;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bcnt == BIT_LAST) begin
          sen_nxt = 1'b1;
          sh_clr  = 1'b1;
          if (idx == IDX_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            mem_a_nxt = BASE + MAW'(idx) + MAW'(1);
            gcnt_nxt  = '0;
            state_nxt = (GAP > 0) ? ST_GAP : ST_FETCH;
          end
        end else begin
          sh_shift = 1'b1;
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt == GAP_LAST) begin
          state_nxt = ST_FETCH;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        idx_nxt   = '0;
        mem_a_nxt = BASE;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      bcnt    <= '0;
      gcnt    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sen_q   <= 1'b1;
      mem_a_q <= BASE;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      bcnt    <= bcnt_nxt;
      gcnt    <= gcnt_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      sen_q   <= sen_nxt;
      mem_a_q <= mem_a_nxt;
    end
  end

  si_shift_out #(
    .W(FW)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (sh_load),
    .shift(sh_shift),
    .clr  (sh_clr),
    .din  (frame),
    .sd   (bus.sd)
  );

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sen    = sen_q;
  assign bus.mem_a  = mem_a_q;
  assign bus.mem_rw = 1'b1;
endmodule

// File: tb/tb_si_frame_tx.sv
// Bench for si_frame_tx: four configurations, serial frames checked against a scoreboard.
// Latency: done latency and sen timing compared against the closed-form counts.
// Backpressure: start re-assertion while busy and on the done cycle must be ignored.
module tb_si_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_v [4];

  always #5 clk = ~clk;

  si_frame_tx_if #(.DW(18), .MAW(3)) if0 ();
  si_frame_tx_if #(.DW(8),  .MAW(5)) if1 ();
  si_frame_tx_if #(.DW(8),  .MAW(3)) if2 ();
  si_frame_tx_if #(.DW(8),  .MAW(3)) if3 ();

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if3.start = start_v[3];

  si_frame_tx #(.IW(3), .DW(18), .MAW(3), .NFRAMES(8), .BASE_ADDR(0), .PARITY_EN(0), .GAP(0))
    u_up   (.clk(clk), .rst(rst), .bus(if0));
  si_frame_tx #(.IW(5), .DW(8), .MAW(5), .NFRAMES(18), .BASE_ADDR(0), .PARITY_EN(0), .GAP(0))
    u_down (.clk(clk), .rst(rst), .bus(if1));
  si_frame_tx #(.IW(3), .DW(8), .MAW(3), .NFRAMES(2), .BASE_ADDR(0), .PARITY_EN(1), .GAP(3))
    u_par  (.clk(clk), .rst(rst), .bus(if2));
  si_frame_tx #(.IW(3), .DW(8), .MAW(3), .NFRAMES(1), .BASE_ADDR(4), .PARITY_EN(0), .GAP(0))
    u_base (.clk(clk), .rst(rst), .bus(if3));

  // Synchronous single-port banks: data valid one cycle after the address edge.
  logic [17:0] bank0 [8];
  logic [7:0]  bank1 [32];
  logic [7:0]  bank2 [8];
  logic [7:0]  bank3 [8];

  always @(posedge clk) begin
    if0.mem_q <= bank0[if0.mem_a];
    if1.mem_q <= bank1[if1.mem_a];
    if2.mem_q <= bank2[if2.mem_a];
    if3.mem_q <= bank3[if3.mem_a];
  end

  logic sen_a [4];
  logic sd_a  [4];
  logic done_a[4];
  logic busy_a[4];
  logic rw_a  [4];
  int   mema_a[4];

  assign sen_a[0] = if0.sen;  assign sen_a[1] = if1.sen;  assign sen_a[2] = if2.sen;  assign sen_a[3] = if3.sen;
  assign sd_a[0]  = if0.sd;   assign sd_a[1]  = if1.sd;   assign sd_a[2]  = if2.sd;   assign sd_a[3]  = if3.sd;
  assign done_a[0] = if0.done; assign done_a[1] = if1.done; assign done_a[2] = if2.done; assign done_a[3] = if3.done;
  assign busy_a[0] = if0.busy; assign busy_a[1] = if1.busy; assign busy_a[2] = if2.busy; assign busy_a[3] = if3.busy;
  assign rw_a[0]  = if0.mem_rw; assign rw_a[1] = if1.mem_rw; assign rw_a[2] = if2.mem_rw; assign rw_a[3] = if3.mem_rw;
  assign mema_a[0] = int'(if0.mem_a); assign mema_a[1] = int'(if1.mem_a);
  assign mema_a[2] = int'(if2.mem_a); assign mema_a[3] = int'(if3.mem_a);

  typedef struct {
    int          inst;
    int          fw;
    logic [63:0] val;
    int          gap;
  } exp_t;

  typedef struct {
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [11:0] f0;
    logic [11:0] f1;
  } par_vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [63:0] acc[4];
  int   nbits[4];
  int   hi_cnt[4];
  int   gap_seen[4];
  logic sen_prev[4];
  int   done_cnt[4] = '{0, 0, 0, 0};
  int   sd_bad = 0;
  int   rw_bad = 0;
  int   fetch_a = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input int fw, input logic [63:0] val, input int gap);
    exp_t e;
    e.inst = inst;
    e.fw   = fw;
    e.val  = val;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic frame_end(input int i);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL frame_unexpected inst%0d: got %0d bits 0x%0h, expected no frame", i, nbits[i], acc[i]);
    end else begin
      e = sb.pop_front();
      if (e.inst != i || e.fw != nbits[i] || e.val != acc[i]) begin
        errors++;
        $display("FAIL frame inst%0d: got %0d bits 0x%0h, expected inst%0d %0d bits 0x%0h",
                 i, nbits[i], acc[i], e.inst, e.fw, e.val);
      end
      if (e.gap >= 0) begin
        checks++;
        if (gap_seen[i] != e.gap) begin
          errors++;
          $display("FAIL gap inst%0d: got %0d idle cycles expected %0d", i, gap_seen[i], e.gap);
        end
      end
    end
  endtask

  // Receiver: sample sd on the falling edge while sen is low, close the frame when sen rises.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        acc[i]      = '0;
        nbits[i]    = 0;
        hi_cnt[i]   = 0;
        gap_seen[i] = -1;
        sen_prev[i] = 1'b1;
      end else begin
        if (done_a[i]) done_cnt[i]++;
        if (!rw_a[i]) rw_bad++;
        if (!sen_a[i]) begin
          if (sen_prev[i]) begin
            gap_seen[i] = hi_cnt[i];
            acc[i]      = '0;
            nbits[i]    = 0;
          end
          acc[i] = {acc[i][62:0], sd_a[i]};
          nbits[i]++;
        end else begin
          if (sd_a[i]) sd_bad++;
          if (!sen_prev[i]) begin
            frame_end(i);
            hi_cnt[i] = 1;
          end else begin
            hi_cnt[i]++;
          end
        end
        sen_prev[i] = sen_a[i];
      end
    end
  end

  // Pulse start, then count cycles from the accepting edge until done is seen.
  task automatic run_transfer(input int i, input int lat, input string name);
    int n;
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    chk({name, " busy_after_accept"}, busy_a[i], 1);
    fetch_a = mema_a[i];
    n = 0;
    while (n < lat + 40 && !done_a[i]) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " done_latency"}, n, lat);
    chk({name, " busy_at_done"}, busy_a[i], 0);
    @(posedge clk); #1;
    chk({name, " done_one_cycle"}, done_a[i], 0);
  endtask

  task automatic push_upload();
    for (int k = 0; k < 8; k++)
      push(0, 21, 64'({3'(k), 18'h2A5A5 ^ 18'(k)}), (k == 0) ? -1 : 2);
  endtask

  initial begin
    par_vec_t pv[3];
    int n;
    int dc;

    pv[0] = '{8'h07, 8'h00, 12'h00F, 12'h201};
    pv[1] = '{8'hFF, 8'h80, 12'h1FE, 12'h300};
    pv[2] = '{8'h01, 8'h5A, 12'h003, 12'h2B5};

    for (int k = 0; k < 8; k++) begin
      bank0[k] = 18'h2A5A5 ^ 18'(k);
      bank2[k] = 8'h00;
      bank3[k] = 8'h30 + 8'(k);
    end
    for (int k = 0; k < 32; k++) bank1[k] = 8'hF0 + 8'(k);
    start_v = '{1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sen", sen_a[0], 1);
    chk("reset sd", sd_a[0], 0);
    chk("reset busy", busy_a[0], 0);
    chk("reset done", done_a[0], 0);
    chk("reset mem_a", mema_a[0], 0);
    chk("reset mem_rw", rw_a[0], 1);
    chk("reset mem_a base4", mema_a[3], 4);
    rst = 1'b0;
    @(posedge clk); #1;

    // Upload profile: 8 frames of 21 bits.
    push_upload();
    run_transfer(0, 185, "upload");
    chk("upload frames consumed", sb.size(), 0);
    chk("upload done count", done_cnt[0], 1);

    // Download profile: 18 frames of 13 bits, data wraps at 8 bits.
    for (int k = 0; k < 18; k++)
      push(1, 13, 64'({5'(k), 8'(8'hF0 + k)}), (k == 0) ? -1 : 2);
    run_transfer(1, 271, "download");
    chk("download frames consumed", sb.size(), 0);
    chk("download done count", done_cnt[1], 1);

    // Parity with GAP=3: table of bank contents and expected frames.
    for (int t = 0; t < 3; t++) begin
      bank2[0] = pv[t].d0;
      bank2[1] = pv[t].d1;
      push(2, 12, 64'(pv[t].f0), -1);
      push(2, 12, 64'(pv[t].f1), 5);
      run_transfer(2, 32, "parity");
      chk("parity frames consumed", sb.size(), 0);
    end
    chk("parity done count", done_cnt[2], 3);

    // Base address 4, single frame.
    push(3, 11, 64'h034, -1);
    run_transfer(3, 14, "base");
    chk("base mem_a in fetch", fetch_a, 4);
    chk("base frames consumed", sb.size(), 0);
    chk("base mem_a after done", mema_a[3], 4);

    // start during frame 2 and on the done cycle must be ignored.
    push_upload();
    dc = done_cnt[0];
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 0;
    while (n < 260 && !done_a[0]) begin
      @(posedge clk); #1;
      n++;
      start_v[0] = (n == 53);
    end
    chk("restart-ignore done_latency", n, 185);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("restart-ignore done count", done_cnt[0], dc + 1);
    chk("restart-ignore busy idle", busy_a[0], 0);
    chk("restart-ignore frames consumed", sb.size(), 0);

    // Reset during bit 10 of frame 4, then restart from frame 0.
    for (int k = 0; k < 4; k++)
      push(0, 21, 64'({3'(k), 18'h2A5A5 ^ 18'(k)}), (k == 0) ? -1 : 2);
    dc = done_cnt[0];
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (int c = 0; c < 104; c++) begin
      @(posedge clk); #1;
    end
    chk("midframe sen low", sen_a[0], 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midframe rst sen", sen_a[0], 1);
    chk("midframe rst sd", sd_a[0], 0);
    chk("midframe rst busy", busy_a[0], 0);
    chk("midframe rst mem_a", mema_a[0], 0);
    chk("midframe rst done", done_a[0], 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midframe no done", done_cnt[0], dc);
    chk("midframe frames consumed", sb.size(), 0);
    push_upload();
    run_transfer(0, 185, "after-reset");
    chk("after-reset frames consumed", sb.size(), 0);
    chk("after-reset done count", done_cnt[0], dc + 1);

    chk("sd low while sen high", sd_bad, 0);
    chk("mem_rw held high", rw_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/si_frame_tx.md
Name: si_frame_tx

Overview:
Parametrised serial frame transmitter. It reads NFRAMES words from a single-port synchronous register bank and emits one serial frame per word on a sen/sd link: {frame index, data, optional parity}, MSB first. It replaces the fixed-width upload (3b index + 18b data) and download (5b index + 8b data) transmitters with one block. It also adds optional even parity, a programmable inter-frame gap and a base address.

Parameters:
IW, 3, frame-index field width in bits
DW, 18, data field width (= bank word width)
MAW, 3, bank address width
NFRAMES, 8, frames per transfer; legal range 1..2**IW and BASE_ADDR+NFRAMES <= 2**MAW
BASE_ADDR, 0, bank address of frame 0
PARITY_EN, 0, 1 = append even-parity bit over index+data as frame LSB
GAP, 0, extra idle cycles (sen=1) inserted after each frame; 0..255

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a transfer; ignored unless idle
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last frame bit
mem_rw  out  1  bank WEN; held 1 (read only)
mem_a  out  MAW  bank address, registered
mem_q  in  DW  bank read data, valid one cycle after address edge
sen  out  1  frame enable, active low, registered
sd  out  1  serial data, registered; 0 when sen=1

Behaviour:
- Frame width FW = IW+DW+PARITY_EN. Frame k = {k[IW-1:0], mem[BASE_ADDR+k], p}. p = XOR of the preceding IW+DW bits (only when PARITY_EN=1).
- Reset values: sen=1, sd=0, busy=0, done=0, mem_a=BASE_ADDR, mem_rw=1. Index, bit and gap counters are 0. FSM is IDLE.
- FSM states: IDLE, FETCH, READ, SHIFT, GAP, DONE.
- IDLE: start=1 at edge -> FETCH; busy=1; mem_a=BASE_ADDR+idx.
- FETCH: 1 cycle; the bank registers the address at the closing edge -> READ.
- READ: 1 cycle; mem_q is valid. At the closing edge: load the shift register with frame k, sd<=frame MSB, sen<=0, then -> SHIFT.
- SHIFT: each bit is held exactly one cycle, FW cycles total, MSB first. After the last bit:
  - sen<=1, sd<=0.
  - If idx==NFRAMES-1 -> DONE.
  - Else idx++, mem_a<=BASE_ADDR+idx+1, then GAP (GAP>0) or FETCH (GAP=0).
- GAP: GAP cycles with sen=1, then -> FETCH.
- DONE: done=1 for one cycle; busy<=0; idx<=0; mem_a<=BASE_ADDR -> IDLE.
- Latency:
  - sen falls 2 cycles after the edge that accepts start.
  - sen stays low exactly FW cycles per frame.
  - Between frames sen stays high GAP+2 cycles.
  - done asserts the cycle after the last data bit.
  - Total transfer = NFRAMES*(FW+2) + (NFRAMES-1)*GAP + 1 cycles from accept to done.
- A receiver sampling sd on posedge while sen=0 sees each bit exactly once.
- start while busy: ignored, no queuing. start coincident with done: ignored.
- rst mid-frame: on the next edge all outputs return to reset values; no partial-frame completion and no done pulse.
- NFRAMES=1: single frame, no GAP state entered.
- Counter widths: idx ceil(log2(NFRAMES+1)), bit counter ceil(log2(FW+1)), gap counter 8b. There is no wrap beyond NFRAMES-1.

Decomposition:
- Package si_pkg:
  - FSM state enum (IDLE..DONE).
  - Function even_parity(vector).
  - Localparam helper for FW.
  - Default widths for upload (IW=3, DW=18) and download (IW=5, DW=8) profiles.
- Sub-module si_shift_out: parallel-load MSB-first shift register with load/shift enables. Width is FW; it drives sd.
- The FSM and counters stay in si_frame_tx.

Test Plan:
- Upload profile (IW=3, DW=18, NFRAMES=8), bank word k = 18'h2A5A5^k, start pulse:
  - 8 frames of 21 bits.
  - Frame 3 reads 3'b011 then 18'h2A5A6.
  - sen low 21 cycles each, high 2 cycles between frames.
  - done at accept+8*23+1 = 185 cycles.
- Download profile (IW=5, DW=8, NFRAMES=18, MAW=5), mem[k]=8'hF0+k:
  - 18 frames of 13 bits; frame 17 = 5'b10001, 8'h01.
  - One done pulse; busy low afterwards.
- PARITY_EN=1, GAP=3, IW=3, DW=8, mem[0]=8'h07, mem[1]=8'h00:
  - Frame 0 = 000_00000111_1; frame 1 = 001_00000000_1.
  - sen high exactly 5 cycles between frames.
- start re-asserted during frame 2 and again on the done cycle: no extra frames; exactly one done per accepted start.
- rst asserted in bit 10 of frame 4:
  - Next edge sen=1, sd=0, busy=0, mem_a=BASE_ADDR, no done.
  - A new start restarts at frame 0.
- BASE_ADDR=4, NFRAMES=1, MAW=3: mem_a=4 during FETCH; one frame with index 0; no GAP state; done at accept+FW+3.
